// File: rtl/brq_mdu_if.sv
// Request/response bundle between the execute stage and the iterative multiply/divide unit.
// The requester (master) drives the request side; the MDU (slave) drives busy/done/result.
interface brq_mdu_if #(
  parameter int DataWidth    = 32,
  parameter int RegAddrWidth = 5
);
  logic                    mdu_start;
  logic [2:0]              mdu_op;
  logic [DataWidth-1:0]    mdu_src_a;
  logic [DataWidth-1:0]    mdu_src_b;
  logic [RegAddrWidth-1:0] mdu_addr_dst;
  logic                    mdu_kill;
  logic                    mdu_busy;
  logic                    mdu_done;
  logic [DataWidth-1:0]    mdu_result;
  logic [RegAddrWidth-1:0] mdu_addr_out;
  logic                    mdu_regfile_en;

  modport master (
    output mdu_start, mdu_op, mdu_src_a, mdu_src_b, mdu_addr_dst, mdu_kill,
    input  mdu_busy, mdu_done, mdu_result, mdu_addr_out, mdu_regfile_en
  );

  modport slave (
    input  mdu_start, mdu_op, mdu_src_a, mdu_src_b, mdu_addr_dst, mdu_kill,
    output mdu_busy, mdu_done, mdu_result, mdu_addr_out, mdu_regfile_en
  );
endinterface

// File: rtl/brq_mdu.sv
// Iterative radix-2 multiply/divide unit for the RV32 M extension.
// One shift-add (multiply) or restoring shift-subtract (divide) step per clock.
module brq_mdu #(
  parameter int DataWidth    = 32,
  parameter int RegAddrWidth = 5
) (
  input logic       brq_clk,
  input logic       brq_rst,
  brq_mdu_if.slave  bus
);

  localparam int CntW = $clog2(DataWidth);
  localparam logic [CntW-1:0]        CntLast = CntW'(DataWidth - 1);
  localparam logic [CntW-1:0]        CntOne  = CntW'(1);
  localparam logic [DataWidth-1:0]   MinNeg  = {1'b1, {(DataWidth-1){1'b0}}};
  localparam logic [DataWidth-1:0]   One     = DataWidth'(1);
  localparam logic [2*DataWidth-1:0] One2    = (2*DataWidth)'(1);

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_e;

  state_e                  state_q, state_d;
  logic [2:0]              op_q;
  logic [DataWidth-1:0]    a_q, b_q, opnd_q;
  logic [RegAddrWidth-1:0] dst_q;
  logic                    neg_q;
  logic [CntW-1:0]         cnt_q;
  logic [2*DataWidth-1:0]  acc_q;
  logic [DataWidth-1:0]    result_q;
  logic [RegAddrWidth-1:0] addr_out_q;

  function automatic logic [DataWidth-1:0] neg_w(input logic [DataWidth-1:0] v);
    return ~v + One;
  endfunction

  function automatic logic [2*DataWidth-1:0] neg_2w(input logic [2*DataWidth-1:0] v);
    return ~v + One2;
  endfunction

  function automatic logic [DataWidth-1:0] mag(input logic [DataWidth-1:0] v, input logic is_signed);
    return (is_signed && v[DataWidth-1]) ? neg_w(v) : v;
  endfunction

  // Request decode and divide early-out detection on the live ports
  logic                 accept, b_zero, div_ovf, early;
  logic [DataWidth-1:0] early_res;

  always_comb begin
    accept    = (state_q == IDLE) && bus.mdu_start && !bus.mdu_kill;
    b_zero    = (bus.mdu_src_b == '0);
    div_ovf   = (bus.mdu_src_a == MinNeg) && (bus.mdu_src_b == '1) && !bus.mdu_op[0];
    early     = bus.mdu_op[2] && (b_zero || div_ovf);
    early_res = '0;
    if (b_zero)
      early_res = bus.mdu_op[1] ? bus.mdu_src_a : '1;
    else
      early_res = bus.mdu_op[1] ? '0 : MinNeg;
  end

  // Operand signedness of the captured op
  logic sgn_a, sgn_b, neg_a, neg_b;

  always_comb begin
    sgn_a = (op_q == 3'd1) || (op_q == 3'd2) || (op_q == 3'd4) || (op_q == 3'd6);
    sgn_b = (op_q == 3'd1) || (op_q == 3'd4) || (op_q == 3'd6);
    neg_a = sgn_a && a_q[DataWidth-1];
    neg_b = sgn_b && b_q[DataWidth-1];
  end

  // One radix-2 step; divide keeps remainder in the high half, quotient shifts into the low half
  logic [DataWidth:0]     mul_sum, rem_ext, diff;
  logic [2*DataWidth-1:0] step_acc;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*DataWidth-1:DataWidth]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    rem_ext  = acc_q[2*DataWidth-1:DataWidth-1];
    diff     = rem_ext - {1'b0, opnd_q};
    step_acc = '0;
    if (!op_q[2])
      step_acc = {mul_sum, acc_q[DataWidth-1:1]};
    else if (diff[DataWidth])
      step_acc = {rem_ext[DataWidth-1:0], acc_q[DataWidth-2:0], 1'b0};
    else
      step_acc = {diff[DataWidth-1:0], acc_q[DataWidth-2:0], 1'b1};
  end

  // Sign fix-up and result select
  logic [2*DataWidth-1:0] prod;
  logic [DataWidth-1:0]   div_sel, fix_res;

  always_comb begin
    prod    = neg_q ? neg_2w(acc_q) : acc_q;
    div_sel = op_q[1] ? acc_q[2*DataWidth-1:DataWidth] : acc_q[DataWidth-1:0];
    if (op_q[2])
      fix_res = neg_q ? neg_w(div_sel) : div_sel;
    else if (op_q[1:0] == 2'd0)
      fix_res = prod[DataWidth-1:0];
    else
      fix_res = prod[2*DataWidth-1:DataWidth];
  end

  always_ff @(posedge brq_clk) begin
    if (brq_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = early ? DONE : PREP;
      PREP:    state_d = bus.mdu_kill ? IDLE : CALC;
      CALC:    if (bus.mdu_kill)        state_d = IDLE;
               else if (cnt_q == CntLast) state_d = FIX;
      FIX:     state_d = bus.mdu_kill ? IDLE : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture -> prepare magnitudes -> iterate
  always_ff @(posedge brq_clk) begin
    case (state_q)
      IDLE: if (accept) begin
        op_q  <= bus.mdu_op;
        a_q   <= bus.mdu_src_a;
        b_q   <= bus.mdu_src_b;
        dst_q <= bus.mdu_addr_dst;
      end
      PREP: begin
        neg_q  <= (op_q[2] && op_q[1]) ? neg_a : (neg_a ^ neg_b);
        opnd_q <= op_q[2] ? mag(b_q, sgn_b) : mag(a_q, sgn_a);
        acc_q  <= {{DataWidth{1'b0}}, op_q[2] ? mag(a_q, sgn_a) : mag(b_q, sgn_b)};
        cnt_q  <= '0;
      end
      CALC: begin
        acc_q <= step_acc;
        if (cnt_q != CntLast) cnt_q <= cnt_q + CntOne;
      end
      default: ;
    endcase
  end

  // Architectural result: only written on completion, so a kill leaves it untouched
  always_ff @(posedge brq_clk) begin
    if (brq_rst) begin
      result_q   <= '0;
      addr_out_q <= '0;
    end else if (accept && early) begin
      result_q   <= early_res;
      addr_out_q <= bus.mdu_addr_dst;
    end else if (state_q == FIX && !bus.mdu_kill) begin
      result_q   <= fix_res;
      addr_out_q <= dst_q;
    end
  end

  assign bus.mdu_busy       = (state_q != IDLE);
  assign bus.mdu_done       = (state_q == DONE);
  assign bus.mdu_regfile_en = (state_q == DONE);
  assign bus.mdu_result     = result_q;
  assign bus.mdu_addr_out   = addr_out_q;

endmodule

// File: tb/tb_brq_mdu.sv
// Directed testbench for brq_mdu (DataWidth=32): hand-computed M-extension results,
// latency, early-out, kill, reset and start-hold behaviour.
module tb_brq_mdu;

  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  brq_mdu_if #(.DataWidth(DW), .RegAddrWidth(AW)) bus ();

  brq_mdu #(.DataWidth(DW), .RegAddrWidth(AW)) dut (
    .brq_clk (clk),
    .brq_rst (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Issue one request, then count edges after the accepting edge until done is seen.
  // lat = 0 means done in the cycle right after the accepting edge; -1 means timeout.
  task automatic do_op(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [AW-1:0] dst, input bit hold,
                       output int lat, output logic [DW-1:0] res, output logic [AW-1:0] adr,
                       output bit busy_ok, output bit wen_ok);
    @(negedge clk);
    bus.mdu_start    = 1'b1;
    bus.mdu_op       = op;
    bus.mdu_src_a    = a;
    bus.mdu_src_b    = b;
    bus.mdu_addr_dst = dst;
    @(posedge clk);
    #1;
    if (!hold) bus.mdu_start = 1'b0;
    bus.mdu_src_a    = $urandom;
    bus.mdu_src_b    = $urandom;
    bus.mdu_addr_dst = AW'($urandom);
    lat     = 0;
    busy_ok = 1'b1;
    @(negedge clk);
    while (!bus.mdu_done && lat < 100) begin
      if (!bus.mdu_busy || bus.mdu_regfile_en) busy_ok = 1'b0;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!bus.mdu_done) lat = -1;
    res    = bus.mdu_result;
    adr    = bus.mdu_addr_out;
    wen_ok = bus.mdu_regfile_en && bus.mdu_busy;
    if (hold) begin
      @(posedge clk);
      #1;
      bus.mdu_start = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.mdu_start = 1'b0; bus.mdu_kill = 1'b0; bus.mdu_op = 3'd0;
    bus.mdu_src_a = '0;   bus.mdu_src_b = '0;  bus.mdu_addr_dst = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (bus.mdu_busy !== 1'b0)       begin n_err++; $display("FAIL rst_busy got=%b exp=0", bus.mdu_busy); end
    n_vec++; if (bus.mdu_done !== 1'b0)       begin n_err++; $display("FAIL rst_done got=%b exp=0", bus.mdu_done); end
    n_vec++; if (bus.mdu_result !== 32'h0)    begin n_err++; $display("FAIL rst_result got=%h exp=0", bus.mdu_result); end
    n_vec++; if (bus.mdu_addr_out !== 5'd0)   begin n_err++; $display("FAIL rst_addr got=%h exp=0", bus.mdu_addr_out); end
    n_vec++; if (bus.mdu_regfile_en !== 1'b0) begin n_err++; $display("FAIL rst_wen got=%b exp=0", bus.mdu_regfile_en); end
    rst = 1'b0;
  endtask

  task automatic test_mul;
    int lat; logic [DW-1:0] r; logic [AW-1:0] ad; bit bok, wok;
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 1'b0, lat, r, ad, bok, wok);
    n_vec++; if (r !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mul_res got=%h exp=ffffffeb", r); end
    n_vec++; if (lat !== 34)          begin n_err++; $display("FAIL mul_lat got=%0d exp=34", lat); end
    n_vec++; if (bok !== 1'b1)        begin n_err++; $display("FAIL mul_busy got=%b exp=1", bok); end
    n_vec++; if (wok !== 1'b1)        begin n_err++; $display("FAIL mul_wen got=%b exp=1", wok); end
    n_vec++; if (ad !== 5'd3)         begin n_err++; $display("FAIL mul_addr got=%0d exp=3", ad); end
    do_op(3'd1, 32'd7, 32'hFFFF_FFFD, 5'd4, 1'b0, lat, r, ad, bok, wok);
    n_vec++; if (r !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mulh_res got=%h exp=ffffffff", r); end
    n_vec++; if (lat !== 34)          begin n_err++; $display("FAIL mulh_lat got=%0d exp=34", lat); end
  endtask

  task automatic test_mul_unsigned;
    int lat; logic [DW-1:0] r; logic [AW-1:0] ad; bit bok, wok;
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 1'b0, lat, r, ad, bok, wok);
    n_vec++; if (r !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL mulhu_res got=%h exp=fffffffe", r); end
    do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd7, 1'b0, lat, r, ad, bok, wok);
    n_vec++; if (r !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mulhsu_res got=%h exp=ffffffff", r); end
    do_op(3'd3, 32'h8000_0000, 32'd6, 5'd8, 1'b0, lat, r, ad, bok, wok);
    n_vec++; if (r !== 32'd3)         begin n_err++; $display("FAIL mulhu_big got=%h exp=3", r); end
  endtask

  task automatic test_div;
    int lat; logic [DW-1:0] r; logic [AW-1:0] ad; bit bok, wok;
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd10, 1'b0, lat, r, ad, bok, wok);
    n_vec++; if (r !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_res got=%h exp=fffffffd", r); end
    n_vec++; if (ad !== 5'd10)        begin n_err++; $display("FAIL div_addr got=%0d exp=10", ad); end
    n_vec++; if (lat !== 34)          begin n_err++; $display("FAIL div_lat got=%0d exp=34", lat); end
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd11, 1'b0, lat, r, ad, bok, wok);
    n_vec++; if (r !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rem_res got=%h exp=ffffffff", r); end
    n_vec++; if (ad !== 5'd11)        begin n_err++; $display("FAIL rem_addr got=%0d exp=11", ad); end
    do_op(3'd5, 32'd100, 32'd7, 5'd12, 1'b0, lat, r, ad, bok, wok);
    n_vec++; if (r !== 32'd14)        begin n_err++; $display("FAIL divu_res got=%h exp=e", r); end
    do_op(3'd7, 32'd100, 32'd7, 5'd13, 1'b0, lat, r, ad, bok, wok);
    n_vec++; if (r !== 32'd2)         begin n_err++; $display("FAIL remu_res got=%h exp=2", r); end
    n_vec++; if (ad !== 5'd13)        begin n_err++; $display("FAIL remu_addr got=%0d exp=13", ad); end
    do_op(3'd5, 32'hFFFF_FFFF, 32'd1, 5'd14, 1'b0, lat, r, ad, bok, wok);
    n_vec++; if (r !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL divu_max got=%h exp=ffffffff", r); end
  endtask

  task automatic test_special;
    int lat; logic [DW-1:0] r; logic [AW-1:0] ad; bit bok, wok;
    do_op(3'd5, 32'd5, 32'd0, 5'd15, 1'b0, lat, r, ad, bok, wok);
    n_vec++; if (r !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL divu0_res got=%h exp=ffffffff", r); end
    n_vec++; if (lat !== 0)           begin n_err++; $display("FAIL divu0_lat got=%0d exp=0", lat); end
    n_vec++; if (ad !== 5'd15)        begin n_err++; $display("FAIL divu0_addr got=%0d exp=15", ad); end
    do_op(3'd7, 32'd5, 32'd0, 5'd16, 1'b0, lat, r, ad, bok, wok);
    n_vec++; if (r !== 32'd5)         begin n_err++; $display("FAIL remu0_res got=%h exp=5", r); end
    n_vec++; if (lat !== 0)           begin n_err++; $display("FAIL remu0_lat got=%0d exp=0", lat); end
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 1'b0, lat, r, ad, bok, wok);
    n_vec++; if (r !== 32'h8000_0000) begin n_err++; $display("FAIL divovf_res got=%h exp=80000000", r); end
    n_vec++; if (lat !== 0)           begin n_err++; $display("FAIL divovf_lat got=%0d exp=0", lat); end
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 1'b0, lat, r, ad, bok, wok);
    n_vec++; if (r !== 32'h0)         begin n_err++; $display("FAIL removf_res got=%h exp=0", r); end
    n_vec++; if (lat !== 0)           begin n_err++; $display("FAIL removf_lat got=%0d exp=0", lat); end
  endtask

  task automatic test_kill;
    int lat; logic [DW-1:0] r; logic [AW-1:0] ad; bit bok, wok; bit saw_done;
    do_op(3'd5, 32'd100, 32'd7, 5'd5, 1'b0, lat, r, ad, bok, wok);
    saw_done = 1'b0;
    @(negedge clk);
    bus.mdu_start = 1'b1; bus.mdu_op = 3'd4; bus.mdu_src_a = 32'd1000; bus.mdu_src_b = 32'd3;
    bus.mdu_addr_dst = 5'd9;
    @(posedge clk);
    #1 bus.mdu_start = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.mdu_done) saw_done = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    bus.mdu_kill = 1'b1;
    @(posedge clk);
    #1 bus.mdu_kill = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.mdu_busy !== 1'b0)     begin n_err++; $display("FAIL kill_busy got=%b exp=0", bus.mdu_busy); end
    n_vec++; if (bus.mdu_result !== 32'd14) begin n_err++; $display("FAIL kill_result got=%h exp=e", bus.mdu_result); end
    n_vec++; if (bus.mdu_addr_out !== 5'd5) begin n_err++; $display("FAIL kill_addr got=%0d exp=5", bus.mdu_addr_out); end
    repeat (40) begin
      if (bus.mdu_done) saw_done = 1'b1;
      @(negedge clk);
    end
    n_vec++; if (saw_done !== 1'b0)         begin n_err++; $display("FAIL kill_nodone got=%b exp=0", saw_done); end
    do_op(3'd0, 32'd3, 32'd4, 5'd20, 1'b0, lat, r, ad, bok, wok);
    n_vec++; if (r !== 32'd12)              begin n_err++; $display("FAIL kill_mul_res got=%h exp=c", r); end
    n_vec++; if (lat !== 34)                begin n_err++; $display("FAIL kill_mul_lat got=%0d exp=34", lat); end
  endtask

  task automatic test_reset_mid_and_hold;
    int lat; logic [DW-1:0] r; logic [AW-1:0] ad; bit bok, wok; bit saw_done;
    @(negedge clk);
    bus.mdu_start = 1'b1; bus.mdu_op = 3'd0; bus.mdu_src_a = 32'd9; bus.mdu_src_b = 32'd9;
    bus.mdu_addr_dst = 5'd21;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus.mdu_start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_vec++; if (bus.mdu_busy !== 1'b0)       begin n_err++; $display("FAIL rstmid_busy got=%b exp=0", bus.mdu_busy); end
    n_vec++; if (bus.mdu_done !== 1'b0)       begin n_err++; $display("FAIL rstmid_done got=%b exp=0", bus.mdu_done); end
    n_vec++; if (bus.mdu_result !== 32'h0)    begin n_err++; $display("FAIL rstmid_result got=%h exp=0", bus.mdu_result); end
    n_vec++; if (bus.mdu_addr_out !== 5'd0)   begin n_err++; $display("FAIL rstmid_addr got=%0d exp=0", bus.mdu_addr_out); end
    n_vec++; if (bus.mdu_regfile_en !== 1'b0) begin n_err++; $display("FAIL rstmid_wen got=%b exp=0", bus.mdu_regfile_en); end
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.mdu_done) saw_done = 1'b1;
    end
    n_vec++; if (saw_done !== 1'b0)           begin n_err++; $display("FAIL rstmid_nodone got=%b exp=0", saw_done); end
    // Start held through busy and the done cycle must yield exactly one op
    do_op(3'd0, 32'd5, 32'd6, 5'd22, 1'b1, lat, r, ad, bok, wok);
    n_vec++; if (r !== 32'd30)                begin n_err++; $display("FAIL hold_res got=%h exp=1e", r); end
    n_vec++; if (lat !== 34)                  begin n_err++; $display("FAIL hold_lat got=%0d exp=34", lat); end
    @(negedge clk);
    n_vec++; if (bus.mdu_busy !== 1'b0)       begin n_err++; $display("FAIL hold_rearm got=%b exp=0", bus.mdu_busy); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mul_unsigned();
    test_div();
    test_special();
    test_kill();
    test_reset_mid_and_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
